// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one registered even-parity check engine among NREQ requesters.
// Each grant yields one tagged result; sticky per-requester flags and a saturating error count are kept.
module parity_check_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_parity,
    input  logic               clr_err,
    output logic [NREQ-1:0]    gnt,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic               rsp_error,
    output logic [NREQ-1:0]    err_sticky,
    output logic [CNTW-1:0]    err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic            par_q, par_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            rsp_error_q, rsp_error_d;
    logic [NREQ-1:0] sticky_q, sticky_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [IDW-1:0]  sel_s;
    logic [DW-1:0]   sel_data_s;

    // Odd number of ones over {data, parity} means the even-parity check failed.
    function automatic logic parity_err(input logic [DW-1:0] d, input logic p);
        return ^{d, p};
    endfunction

    // First requesting index at or above p, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] pick;
        logic           found;
        logic [IDW:0]   idx;
        pick  = {IDW{1'b0}};
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, p} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end else begin
                idx = idx;
            end
            if (!found && r[idx[IDW-1:0]]) begin
                pick  = idx[IDW-1:0];
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
        return {{(NREQ-1){1'b0}}, 1'b1} << i;
    endfunction

    // Arbitration winner and its data slice.
    always_comb begin
        sel_s      = rr_pick(req, ptr_q);
        sel_data_s = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (sel_s == IDW'(i)) begin
                sel_data_s = req_data[i*DW +: DW];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // FSM next state, capture registers and response outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = {NREQ{1'b0}};
        data_d      = data_q;
        par_d       = par_q;
        id_d        = id_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = onehot(sel_s);
                    data_d  = sel_data_s;
                    par_d   = req_parity[sel_s];
                    id_d    = sel_s;
                    state_d = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_error_d = parity_err(data_q, par_q);
                ptr_d       = (id_q == IDW'(NREQ-1)) ? {IDW{1'b0}} : id_q + IDW'(1);
                state_d     = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Error bookkeeping happens as RESP is left; a coincident clear wins.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clr_err) begin
            sticky_d = {NREQ{1'b0}};
            count_d  = {CNTW{1'b0}};
        end else if ((state_q == S_RESP) && rsp_error_q) begin
            sticky_d = sticky_q | onehot(rsp_id_q);
            count_d  = (count_q == {CNTW{1'b1}}) ? count_q : count_q + CNTW'(1);
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= {IDW{1'b0}};
            gnt_q       <= {NREQ{1'b0}};
            data_q      <= {DW{1'b0}};
            par_q       <= 1'b0;
            id_q        <= {IDW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= {IDW{1'b0}};
            rsp_error_q <= 1'b0;
            sticky_q    <= {NREQ{1'b0}};
            count_q     <= {CNTW{1'b0}};
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            data_q      <= data_d;
            par_q       <= par_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_error_q <= rsp_error_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_error  = rsp_error_q;
    assign err_sticky = sticky_q;
    assign err_count  = count_q;

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Bench for parity_check_arbiter: directed table, corner sequences and random traffic against
// a transaction-level reference model; a second instance with a 2-bit counter checks saturation.
module tb_parity_check_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  req_parity;
    logic        clr_err;

    logic [3:0]  gnt, err_sticky;
    logic        rsp_valid, rsp_error;
    logic [1:0]  rsp_id;
    logic [7:0]  err_count;

    logic [3:0]  sat_gnt, sat_sticky;
    logic        sat_rv, sat_rerr;
    logic [1:0]  sat_rid;
    logic [1:0]  sat_count;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int         m_phase, m_ptr, m_rid, m_pid, m_cnt, m_cnt2;
    logic [3:0] m_gnt, m_sticky;
    logic       m_rv, m_rerr, m_perr;

    typedef struct {
        int         r;
        logic [3:0] d;
        logic       p;
        logic [3:0] eg;
        logic       eerr;
    } vec_t;
    vec_t tbl[5];

    parity_check_arbiter #(.NREQ(4), .DW(4), .IDW(2), .CNTW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_parity(req_parity),
        .clr_err(clr_err), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_error(rsp_error), .err_sticky(err_sticky), .err_count(err_count)
    );

    parity_check_arbiter #(.NREQ(4), .DW(4), .IDW(2), .CNTW(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_parity(req_parity),
        .clr_err(clr_err), .gnt(sat_gnt), .rsp_valid(sat_rv), .rsp_id(sat_rid),
        .rsp_error(sat_rerr), .err_sticky(sat_sticky), .err_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock edge of the reference model, using the inputs currently applied.
    task automatic model_edge();
        int win;
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_gnt = 4'b0000; m_rv = 1'b0; m_rid = 0; m_rerr = 1'b0;
            m_sticky = 4'b0000; m_cnt = 0; m_cnt2 = 0;
            return;
        end
        if (clr_err) begin
            m_sticky = 4'b0000; m_cnt = 0; m_cnt2 = 0;
        end else if (m_phase == 2 && m_rerr) begin
            m_sticky[m_rid] = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        case (m_phase)
            0: begin
                m_gnt = 4'b0000;
                m_rv  = 1'b0;
                win   = -1;
                for (int k = 0; k < NREQ; k++)
                    if (win < 0 && req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
                if (win >= 0) begin
                    m_gnt   = 4'b0001 << win;
                    m_pid   = win;
                    m_perr  = ($countones({req_data[win*4 +: 4], req_parity[win]}) % 2) == 1;
                    m_phase = 1;
                end
            end
            1: begin
                m_gnt = 4'b0000; m_rv = 1'b1; m_rid = m_pid; m_rerr = m_perr;
                m_ptr = (m_pid + 1) % NREQ; m_phase = 2;
            end
            default: begin
                m_rv = 1'b0; m_phase = 0;
            end
        endcase
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("gnt", gnt, m_gnt);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_id", rsp_id, m_rid);
        chk("rsp_error", rsp_error, m_rerr);
        chk("err_sticky", err_sticky, m_sticky);
        chk("err_count", err_count, m_cnt);
        chk("err_count_sat", sat_count, m_cnt2);
    endtask

    initial begin
        logic [3:0] seq[$];
        int         seq_cyc[$];
        int         exp_sat[5];
        logic [3:0] exp_seq[5];

        tbl[0] = '{0, 4'b0001, 1'b1, 4'b0001, 1'b0};
        tbl[1] = '{2, 4'b1011, 1'b0, 4'b0100, 1'b1};
        tbl[2] = '{2, 4'b1100, 1'b1, 4'b0100, 1'b1};
        tbl[3] = '{3, 4'b0000, 1'b0, 4'b1000, 1'b0};
        tbl[4] = '{1, 4'b1111, 1'b1, 4'b0010, 1'b1};
        exp_sat = '{1, 2, 3, 3, 3};
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n = 1'b0; req = 4'b0000; req_data = 16'h0000; req_parity = 4'b0000; clr_err = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("reset_gnt", gnt, 4'b0000);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_err_count", err_count, 8'd0);

        // directed single-requester table
        for (int i = 0; i < 5; i++) begin
            req_data = 16'h0000;
            req_data[tbl[i].r*4 +: 4] = tbl[i].d;
            req_parity = 4'b0000;
            req_parity[tbl[i].r] = tbl[i].p;
            req = 4'b0001 << tbl[i].r;
            step();
            chk("tbl_gnt", gnt, tbl[i].eg);
            req = 4'b0000;
            step();
            chk("tbl_valid", rsp_valid, 1'b1);
            chk("tbl_id", rsp_id, tbl[i].r);
            chk("tbl_err", rsp_error, tbl[i].eerr);
            step();
        end
        chk("tbl_total_count", err_count, 8'd3);
        chk("tbl_total_sticky", err_sticky, 4'b0110);

        // all requesters held high: fairness order at 3-cycle spacing
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req_data = {4{4'b1011}}; req_parity = 4'b1111; req = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            step();
            if (gnt != 4'b0000) begin
                seq.push_back(gnt);
                seq_cyc.push_back(c);
            end
        end
        chk("fair_count", seq.size(), 5);
        for (int i = 0; i < 5 && i < seq.size(); i++) begin
            chk("fair_gnt", seq[i], exp_seq[i]);
            chk("fair_spacing", seq_cyc[i], 3 * i);
        end
        req = 4'b0000; step(); step(); step();

        // pointer wrap: after a grant to 1, requesters 0 and 3 go 3 then 0
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req = 4'b0010; step(); req = 4'b0000; step(); step();
        req = 4'b1001; step();
        chk("wrap_first", gnt, 4'b1000);
        req = 4'b0001; step(); step(); step();
        chk("wrap_second", gnt, 4'b0001);
        req = 4'b0000; step(); step();

        // reset during GRANT discards the check
        req = 4'b1000; step();
        chk("rstg_gnt", gnt, 4'b1000);
        rst_n = 1'b0; req = 4'b0000; step();
        chk("rstg_rv", rsp_valid, 1'b0);
        chk("rstg_gnt0", gnt, 4'b0000);
        rst_n = 1'b1; req = 4'b1001; step();
        chk("rstg_prio", gnt, 4'b0001);
        req = 4'b0000; step(); step();

        // saturation of 2-bit counter, then clear coinciding with an error
        req_data[7:4] = 4'b0001; req_parity[1] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            req = 4'b0010; step(); req = 4'b0000; step(); step();
            chk("sat_count_seq", sat_count, exp_sat[n]);
            chk("sat_main_count", err_count, n + 1);
        end
        req = 4'b0010; step(); req = 4'b0000; step();
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("clr_wins_count", err_count, 8'd0);
        chk("clr_wins_sticky", err_sticky, 4'b0000);
        chk("clr_wins_sat", sat_count, 2'd0);

        // random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && m_gnt[i]) begin
                    req[i] = 1'b0;
                end else if (req[i] && ($urandom % 64 == 0)) begin
                    req[i] = 1'b0;
                end else if (!req[i] && ($urandom % 4 == 0)) begin
                    req[i] = 1'b1;
                    req_data[i*4 +: 4] = 4'($urandom);
                    req_parity[i] = 1'($urandom);
                end
            end
            clr_err = ($urandom % 32 == 0);
            rst_n   = ($urandom % 400 != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/parity_check_arbiter.md
Name: parity_check_arbiter

Overview:
- Shares one registered even-parity check engine (4-bit data + 1 parity bit) among NREQ requesters.
- Arbitration is round-robin. Each requester gets one check per grant.
- Result is returned tagged with the requester id. Per-requester sticky error flags and a saturating global error counter are kept.
- Sits between the nibble producers and the link-status logic; replaces per-source combinational checkers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 4, data width per check.
- IDW, 2, requester id width, equal to clog2(NREQ).
- CNTW, 8, global error counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester request; held high with data stable until the matching gnt bit is seen.
- req_data  in  NREQ*DW  packed data; requester i uses bits [i*DW +: DW].
- req_parity  in  NREQ  per-requester parity bit.
- gnt  out  NREQ  one-hot, registered, one-cycle pulse; data for that requester is captured on the same edge that raises it.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  IDW  requester index of the result.
- rsp_error  out  1  1 = parity error, i.e. odd count of ones over {data, parity}.
- err_sticky  out  NREQ  per-requester sticky error flag.
- err_count  out  CNTW  total errors seen, saturating.
- clr_err  in  1  synchronous clear of err_sticky and err_count.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; gnt=0, rsp_valid=0, rsp_id=0, rsp_error=0, err_sticky=0, err_count=0; round-robin pointer=0, so requester 0 has top priority. Reset mid-check discards the in-flight check with no response.
- FSM states: IDLE -> GRANT -> RESP -> IDLE.
- IDLE:
  - req is sampled.
  - If req is nonzero, select the first set bit searching upward from ptr, wrapping modulo NREQ.
  - At the edge: gnt[sel]=1, latch req_data slice and req_parity[sel] into the data/parity registers, latch sel into the id register, go to GRANT.
  - If req==0, stay in IDLE with gnt=0.
- GRANT:
  - gnt is high this cycle only.
  - Check is computed: err = XOR-reduce of {data_reg, parity_reg}.
  - At the edge: gnt=0; rsp_valid=1, rsp_id=id_reg, rsp_error=err; ptr = (id_reg+1) mod NREQ; go to RESP.
- RESP:
  - rsp_valid is high this cycle only.
  - At the edge: rsp_valid=0; go to IDLE.
- Timing:
  - Request sampled in cycle T gives gnt in T+1 and rsp_valid in T+2.
  - Next arbitration happens in T+3, so one check per 3 cycles at maximum.
  - rsp_id and rsp_error hold their values until the next response.
- Requester obligations:
  - Drop req at the edge after seeing gnt.
  - req changes outside IDLE are ignored.
  - A req dropped before being granted is simply not served.
- Fairness: with all req set continuously, grant order is 0,1,2,3,0,... and no requester waits more than NREQ grants.
- Error accounting, applied at the edge that leaves RESP when rsp_error=1:
  - err_sticky[rsp_id] is set.
  - err_count increments, saturating at 2^CNTW-1 (no wrap).
- clr_err:
  - Clears err_sticky and err_count at the edge.
  - If it coincides with an error update, the clear wins and that error is not recorded.
  - It does not affect the FSM, ptr or rsp_* outputs.
- Arithmetic: ptr wraps modulo NREQ. Widths are fixed by parameters; no carry out of err_count.

Test Plan:
- Reset, then single requester 0 with data=4'b0001, parity=1 → gnt=4'b0001 at T+1; rsp_valid at T+2 with rsp_id=0, rsp_error=0; err_count=0.
- Requester 2 with data=4'b1011, parity=0 → rsp_id=2, rsp_error=1; err_sticky=4'b0100 and err_count=1 after RESP. Repeat with data=4'b1100, parity=1 → err_count=2.
- All four req held high, all with valid parity (data=4'b1011, parity=1) → gnt sequence 0001,0010,0100,1000,0001 at 3-cycle spacing; every rsp_error=0.
- After a grant to requester 1, only requesters 0 and 3 request → next grant goes to 3, then 0 (pointer wrap).
- CNTW=2, force 5 errors → err_count goes 1,2,3,3,3. Assert clr_err on the same cycle as an error → err_count=0 and err_sticky=0.
- Assert rst_n=0 during GRANT → no rsp_valid pulse; all outputs 0 next cycle. After release, requester 0 has priority over requester 3 when both request.
